// File: rtl/mac_pe_lanes.sv
// Systolic multiply-accumulate PE: LANES-wide dot product feeding a
// chain/local accumulator, with registered data/weight forwarding.
module mac_pe_lanes #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int SATURATE   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [1:0]                  op,
  input  logic                        mode_signed,
  input  logic [LANES*DATA_WIDTH-1:0] data_in,
  input  logic [LANES*DATA_WIDTH-1:0] wt_in,
  input  logic [ACC_WIDTH-1:0]        acc_in,
  output logic [LANES*DATA_WIDTH-1:0] data_out,
  output logic [LANES*DATA_WIDTH-1:0] wt_out,
  output logic                        fwd_valid,
  output logic [ACC_WIDTH-1:0]        acc_out,
  output logic                        out_valid,
  output logic                        sat_flag
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int EW = ACC_WIDTH + 2;

  function automatic logic [PW-1:0] mul(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          s
  );
    logic signed [DW:0]     ea;
    logic signed [DW:0]     eb;
    logic signed [2*DW+1:0] p;
    ea = {s & a[DW-1], a};
    eb = {s & b[DW-1], b};
    p  = ea * eb;
    return p[PW-1:0];
  endfunction

  function automatic logic [EW-1:0] ext_p(
    input logic [PW-1:0] p,
    input logic          s
  );
    return {{(EW-PW){s & p[PW-1]}}, p};
  endfunction

  function automatic logic [EW-1:0] ext_a(
    input logic [AW-1:0] a,
    input logic          s
  );
    return {{(EW-AW){s & a[AW-1]}}, a};
  endfunction

  logic [LANES-1:0][PW-1:0] prod;
  logic [LANES-1:0][PW-1:0] s1_prod;
  logic [1:0]               s1_op;
  logic                     s1_mode;
  logic [AW-1:0]            s1_acc;
  logic                     s1_valid;

  logic [EW-1:0] dot;
  logic [EW-1:0] base;
  logic [EW-1:0] sum;
  logic [AW-1:0] res;
  logic          ovf;

  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = mul(data_in[i*DW +: DW], wt_in[i*DW +: DW], mode_signed);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      wt_out    <= '0;
      fwd_valid <= 1'b0;
      s1_prod   <= '0;
      s1_op     <= 2'b00;
      s1_mode   <= 1'b0;
      s1_acc    <= '0;
      s1_valid  <= 1'b0;
    end else begin
      data_out  <= data_in;
      wt_out    <= wt_in;
      fwd_valid <= in_valid;
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_prod <= prod;
        s1_op   <= op;
        s1_mode <= mode_signed;
        s1_acc  <= acc_in;
      end
    end
  end

  // Local op reads acc_out directly so back-to-back beats need no bubble
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + ext_p(s1_prod[i], s1_mode);
    end
    base = (s1_op == 2'b01) ? ext_a(s1_acc, s1_mode)
                            : ext_a(acc_out, s1_mode);
    sum  = base + dot;
    if (s1_mode) begin
      ovf = (|sum[EW-1:AW-1]) & ~(&sum[EW-1:AW-1]);
    end else begin
      ovf = |sum[EW-1:AW];
    end
    res = sum[AW-1:0];
    if (ovf && SATURATE != 0) begin
      if (!s1_mode) begin
        res = '1;
      end else if (sum[EW-1]) begin
        res = {1'b1, {(AW-1){1'b0}}};
      end else begin
        res = {1'b0, {(AW-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_out   <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        unique case (s1_op)
          2'b00: acc_out <= s1_acc;
          2'b01,
          2'b10: begin
            acc_out  <= res;
            sat_flag <= sat_flag | ovf;
          end
          2'b11: begin
            acc_out  <= '0;
            sat_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_pe_lanes.sv
// Scoreboard bench for mac_pe_lanes: saturating and wrapping instances
// share stimulus and are checked against an integer reference model.
module tb_mac_pe_lanes;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          mode_signed = 1'b0;
  logic [31:0]   data_in = '0;
  logic [31:0]   wt_in = '0;
  logic [AW-1:0] acc_in = '0;

  logic [31:0]   d_s, w_s, d_w, w_w;
  logic          fv_s, fv_w, ov_s, ov_w, sf_s, sf_w;
  logic [AW-1:0] acc_s, acc_w;

  mac_pe_lanes #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .op(op),
    .mode_signed(mode_signed), .data_in(data_in), .wt_in(wt_in),
    .acc_in(acc_in), .data_out(d_s), .wt_out(w_s), .fwd_valid(fv_s),
    .acc_out(acc_s), .out_valid(ov_s), .sat_flag(sf_s)
  );

  mac_pe_lanes #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .op(op),
    .mode_signed(mode_signed), .data_in(data_in), .wt_in(wt_in),
    .acc_in(acc_in), .data_out(d_w), .wt_out(w_w), .fwd_valid(fv_w),
    .acc_out(acc_w), .out_valid(ov_w), .sat_flag(sf_w)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses_w = 0;

  logic [AW:0]   q_s[$];
  logic [AW:0]   q_w[$];
  logic [AW-1:0] m_acc_s = '0, m_acc_w = '0;
  bit            m_flag_s = 0, m_flag_w = 0;

  logic [31:0]   exp_d, exp_w;
  logic          exp_fv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sval(input logic [63:0] v, input int w, input bit s);
    longint r;
    r = longint'(v & ((64'd1 << w) - 1));
    if (s && v[w-1]) r = r - (longint'(1) <<< w);
    return r;
  endfunction

  task automatic model_step(input bit satur, input logic [1:0] o,
                            input logic [31:0] d, input logic [31:0] w,
                            input logic [AW-1:0] ai, input bit s,
                            inout logic [AW-1:0] acc, inout bit flag);
    longint dot, sum, lo, hi;
    dot = 0;
    for (int i = 0; i < LN; i++)
      dot += sval(64'(d[i*DW +: DW]), DW, s) * sval(64'(w[i*DW +: DW]), DW, s);
    lo = s ? -(longint'(1) <<< (AW-1)) : 0;
    hi = s ? (longint'(1) <<< (AW-1)) - 1 : (longint'(1) <<< AW) - 1;
    case (o)
      2'b00: acc = ai;
      2'b11: begin acc = '0; flag = 0; end
      default: begin
        sum = ((o == 2'b01) ? sval(64'(ai), AW, s) : sval(64'(acc), AW, s)) + dot;
        if (sum > hi || sum < lo) begin
          flag = 1;
          if (satur) acc = (sum > hi) ? hi[AW-1:0] : lo[AW-1:0];
          else       acc = sum[AW-1:0];
        end else begin
          acc = sum[AW-1:0];
        end
      end
    endcase
  endtask

  task automatic beat(input logic [1:0] o, input logic [31:0] d,
                      input logic [31:0] w, input logic [AW-1:0] ai, input bit s);
    op = o; data_in = d; wt_in = w; acc_in = ai; mode_signed = s;
    in_valid = 1'b1;
    model_step(1, o, d, w, ai, s, m_acc_s, m_flag_s);
    model_step(0, o, d, w, ai, s, m_acc_w, m_flag_w);
    q_s.push_back({m_flag_s, m_acc_s});
    q_w.push_back({m_flag_w, m_acc_w});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_d = '0; exp_w = '0; exp_fv = 1'b0;
    end else begin
      exp_d = data_in; exp_w = wt_in; exp_fv = in_valid;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("fwd_data", 64'(d_s), 64'(exp_d));
      chk("fwd_wt", 64'(w_w), 64'(exp_w));
      chk("fwd_valid", 64'(fv_s), 64'(exp_fv));
      if (ov_s) begin
        if (q_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL sat_unexpected: got out_valid=1 expected no output");
        end else begin
          chk("sat_result", 64'({sf_s, acc_s}), 64'(q_s.pop_front()));
        end
      end
      if (ov_w) begin
        pulses_w++;
        if (q_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL wrap_unexpected: got out_valid=1 expected no output");
        end else begin
          chk("wrap_result", 64'({sf_w, acc_w}), 64'(q_w.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_acc", 64'(acc_s), 64'(0));
    chk("reset_ov", 64'(ov_s), 64'(0));
    chk("reset_flag", 64'(sf_w), 64'(0));

    // chain, unsigned
    beat(2'b01, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 24'd100, 0);
    idle(2);
    chk("chain_170", 64'(acc_s), 64'(170));

    // local back-to-back
    beat(2'b11, '0, '0, '0, 0);
    repeat (3) beat(2'b10, {4{8'd2}}, {4{8'd3}}, '0, 0);
    idle(2);
    chk("local_72", 64'(acc_s), 64'(72));

    // signed
    beat(2'b01, {4{8'h80}}, {4{8'h7F}}, '0, 1);
    idle(2);
    chk("signed_acc", 64'(acc_s), 64'(24'hFF0200));

    // saturation then clear
    beat(2'b01, {24'd0, 8'd127}, {24'd0, 8'd127}, 24'h7FFF00, 1);
    idle(2);
    chk("sat_acc", 64'(acc_s), 64'(24'h7FFFFF));
    chk("sat_flag", 64'(sf_s), 64'(1));
    chk("wrap_flag_signed", 64'(sf_w), 64'(1));
    beat(2'b11, '0, '0, '0, 1);
    idle(2);
    chk("clr_acc", 64'(acc_s), 64'(0));
    chk("clr_flag", 64'(sf_s), 64'(0));

    // wrap with bubbles
    idle(2);
    p0 = pulses_w;
    beat(2'b01, 32'd1, 32'd1, 24'hFFFFFF, 0);
    idle(2);
    chk("wrap_acc", 64'(acc_w), 64'(0));
    chk("wrap_flag", 64'(sf_w), 64'(1));
    chk("sat_clamp_u", 64'(acc_s), 64'(24'hFFFFFF));
    beat(2'b00, 32'd0, 32'd0, 24'd5, 0);
    chk("wrap_hold", 64'(acc_w), 64'(0));
    idle(2);
    chk("wrap_pass5", 64'(acc_w), 64'(5));
    chk("wrap_pulses", 64'(pulses_w - p0), 64'(2));

    // asynchronous reset mid-pipeline
    beat(2'b00, '0, '0, 24'h000123, 0);
    idle(2);
    chk("pre_reset_acc", 64'(acc_s), 64'(24'h000123));
    beat(2'b01, 32'h01020304, 32'h05060708, 24'd9, 0);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_acc", 64'(acc_s), 64'(0));
    chk("async_ov", 64'(ov_s), 64'(0));
    chk("async_flag", 64'(sf_w), 64'(0));
    chk("async_data", 64'(d_s), 64'(0));
    q_s.delete(); q_w.delete();
    m_acc_s = '0; m_acc_w = '0; m_flag_s = 0; m_flag_w = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [1:0]    o;
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        o = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
          0: a = 24'hFFFFF0 | 24'($urandom_range(0, 15));
          1: a = 24'h7FFF00 | 24'($urandom_range(0, 255));
          2: a = 24'h800000 | 24'($urandom_range(0, 255));
          default: a = 24'($urandom);
        endcase
        beat(o, $urandom, $urandom, a, 1'($urandom_range(0, 1)));
      end
    end
    idle(4);
    chk("drain_sat", 64'(q_s.size()), 64'(0));
    chk("drain_wrap", 64'(q_w.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_pe_lanes.md
Name: mac_pe_lanes

Overview:
- Next-generation systolic multiply-accumulate processing element.
- Computes a LANES-wide dot product of data and weight vectors and adds it to either the upstream partial sum or its own accumulator.
- Supports weight-stationary chaining and output-stationary accumulation in one block.
- Signed or unsigned operands are selected at runtime; the accumulator can optionally saturate; data and weight are forwarded through registers so the PE tiles into a grid without long combinational chains.

Parameters:
- DATA_WIDTH, 8, width of each data/weight lane element.
- LANES, 4, number of parallel multiply lanes per PE (>=1).
- ACC_WIDTH, 24, accumulator and partial-sum width; must be >= 2*DATA_WIDTH + clog2(LANES).
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies data_in, wt_in, acc_in and op this cycle.
- op  in  2  00 = pass acc_in; 01 = chain (acc_in + dot); 10 = local (acc_out + dot); 11 = clear.
- mode_signed  in  1  1 = operands and accumulator are two's complement; 0 = unsigned.
- data_in  in  LANES*DATA_WIDTH  data vector, lane i at bits [i*DW +: DW].
- wt_in  in  LANES*DATA_WIDTH  weight vector, same packing.
- acc_in  in  ACC_WIDTH  upstream partial sum.
- data_out  out  LANES*DATA_WIDTH  data_in registered (1 cycle).
- wt_out  out  LANES*DATA_WIDTH  wt_in registered (1 cycle).
- fwd_valid  out  1  in_valid registered (1 cycle); qualifies data_out and wt_out.
- acc_out  out  ACC_WIDTH  accumulator result.
- out_valid  out  1  acc_out updated this cycle.
- sat_flag  out  1  sticky: a saturation or overflow has occurred since the last clear.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs and internal pipeline registers go to 0 immediately and stay 0 until the first clk edge after release.
- Forwarding: data_out, wt_out and fwd_valid capture their inputs every cycle regardless of in_valid; latency 1.
- Stage 1 (edge N): when in_valid, register LANES products, op, mode_signed and acc_in; s1_valid <= in_valid.
  - Products are 2*DATA_WIDTH wide, sign- or zero-extended per mode_signed.
  - When in_valid = 0, s1_valid = 0 and the other stage-1 registers hold.
- Stage 2 (edge N+1): when s1_valid, dot = sum of the products, extended to ACC_WIDTH+2 bits. Then:
  - op 00: acc_out <= acc_in.
  - op 01: acc_out <= sat(acc_in + dot).
  - op 10: acc_out <= sat(acc_out + dot). Uses the stage-2 register itself, so back-to-back op 10 beats accumulate correctly with no bubble.
  - op 11: acc_out <= 0 and sat_flag <= 0.
- out_valid <= s1_valid. acc_out holds while s1_valid = 0. Result latency is 2 cycles from in_valid.
- sat() with SATURATE = 1:
  - Unsigned: result > 2^ACC_WIDTH - 1 clamps to all-ones.
  - Signed: clamp to 2^(ACC_WIDTH-1) - 1 or -2^(ACC_WIDTH-1).
  - Any clamp sets sat_flag.
- sat() with SATURATE = 0: result truncated to ACC_WIDTH bits; sat_flag is set on overflow (same detection) but the value wraps.
- sat_flag is sticky; only op 11 or reset clears it.
- mode_signed is sampled per beat. Mixing modes across beats is legal; interpretation of acc_out follows the current beat's mode.
- If reset_n is asserted mid-pipeline, the in-flight beats are discarded. No out_valid is produced for them after release.
- Gaps in in_valid are allowed anywhere with no loss or duplication of beats.

Test Plan:
- Reset: drive reset_n low mid-operation with acc_out = 0x000123 -> acc_out, out_valid, sat_flag and data_out are 0 immediately, before the next clk edge.
- Chain, unsigned, LANES = 4:
  - Stimulus: data = {1,2,3,4}, wt = {5,6,7,8}, acc_in = 100, op 01.
  - Required: 2 cycles later out_valid = 1, acc_out = 170; data_out and wt_out equal their inputs 1 cycle after.
- Local accumulate, back to back:
  - Stimulus: op 11, then three consecutive op 10 beats with data = {2,2,2,2}, wt = {3,3,3,3}.
  - Required: acc_out sequence 0, 24, 48, 72 on consecutive cycles.
- Signed mode:
  - Stimulus: mode_signed = 1, data = {-128,-128,-128,-128}, wt = {127,127,127,127}, acc_in = 0, op 01.
  - Required: acc_out = -65024 (0xFF0200).
- Saturation, SATURATE = 1, signed:
  - Stimulus: acc_in = 0x7FFF00, data = {127,0,0,0}, wt = {127,0,0,0}, op 01.
  - Required: acc_out = 0x7FFFFF and sat_flag = 1. A subsequent op 11 gives acc_out = 0 and sat_flag = 0.
- Wrap and bubbles, SATURATE = 0, unsigned:
  - Stimulus: acc_in = 0xFFFFFF, dot = 1, in_valid = 1,0,0,1 with op 01 then op 00 (acc_in = 5).
  - Required: acc_out = 0x000000 with sat_flag = 1; acc_out holds over the bubbles; then acc_out = 5. out_valid pulses exactly twice.
